// File: rtl/l1d_pkg.sv
// l1d_pkg: FSM state type and default geometry shared by the L1 data cache files.
package l1d_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WAYS_DEF = 4;
    localparam int SETS_DEF = 16;
    localparam int WORDS_PER_LINE_DEF = 8;
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, WR_REQ, WR_WAIT, RESP} state_t;
endpackage

// File: rtl/l1d_repl.sv
// l1d_repl: per-set replacement state and victim choice.
// FIFO round-robin pointer by default; true LRU age counters when L1D_LRU_EN is defined.
module l1d_repl
    import l1d_pkg::*;
#(
    parameter int WAYS = WAYS_DEF,
    parameter int SETS = SETS_DEF,
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1,
    localparam int IW = $clog2(SETS)
)(
    input  logic          CLK,
    input  logic          RST,
    input  logic [IW-1:0] set_idx,
    input  logic          hit_en,
    input  logic [WW-1:0] hit_way,
    input  logic          fill_en,
    input  logic [WW-1:0] fill_way,
    output logic [WW-1:0] victim
);
`ifdef L1D_LRU_EN
    logic [WW-1:0] age [SETS][WAYS];
    logic [WW-1:0] oldest, upd_way, ref_age;
    assign upd_way = fill_en ? fill_way : hit_way;
    // A fill ages every other way as if the new line came from the oldest slot.
    assign ref_age = fill_en ? WW'(WAYS - 1) : age[set_idx][hit_way];
    always_comb begin
        victim = '0;
        oldest = '0;
        for (int w = 0; w < WAYS; w++)
            if (age[set_idx][w] > oldest) begin
                victim = WW'(w);
                oldest = age[set_idx][w];
            end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= '0;
        end else if (hit_en || fill_en) begin
            for (int w = 0; w < WAYS; w++)
                age[set_idx][w] <= WW'(w) == upd_way ? '0 : age[set_idx][w] + WW'(age[set_idx][w] < ref_age);
        end
    end
`else
    logic [WW-1:0] ptr [SETS];
    logic unused_hit;
    assign unused_hit = ^{hit_en, hit_way, fill_way};
    assign victim = ptr[set_idx];
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++)
                ptr[s] <= '0;
        end else if (fill_en) begin
            ptr[set_idx] <= WAYS > 1 ? ptr[set_idx] + 1'b1 : '0;
        end
    end
`endif
endmodule

// File: rtl/l1d_setassoc_cache.sv
// l1d_setassoc_cache: blocking write-through, no-write-allocate set-associative L1 data cache.
// Replacement is FIFO unless L1D_LRU_EN is defined (true LRU).
module l1d_setassoc_cache
    import l1d_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAYS = WAYS_DEF,
    parameter int SETS = SETS_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ_VALID,
    output logic              CPU_REQ_READY,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_RESP_VALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_HIT,
    output logic              MEM_REQ_VALID,
    input  logic              MEM_REQ_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_RDATA_VALID,
    input  logic [DATA_W-1:0] MEM_RDATA
);
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(SETS);
    localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int TW = ADDR_W - IW - OW;

    state_t state;
    logic [ADDR_W-1:0] addr_q;
    logic we_q, hit, hit_q, last_beat;
    logic [DATA_W-1:0] wdata_q;
    logic [TW-1:0] tag_mem [WAYS][SETS];
    logic [DATA_W-1:0] data_mem [WAYS][SETS][WORDS_PER_LINE];
    logic [DATA_W-1:0] line_buf [WORDS_PER_LINE];
    logic [WAYS-1:0] valid [SETS];
    logic [WAYS-1:0] hit_vec;
    logic [OW-1:0] beat, off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [WW-1:0] hit_way, victim, repl_victim, vict_q;

    assign off = addr_q[OW-1:0];
    assign idx = addr_q[OW+IW-1:OW];
    assign tag = addr_q[ADDR_W-1:OW+IW];
    assign hit = |hit_vec;
    assign last_beat = state == REFILL && MEM_RDATA_VALID && beat == OW'(WORDS_PER_LINE - 1);
    assign CPU_REQ_READY = state == IDLE && !RST;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            hit_vec[w] = valid[idx][w] && tag_mem[w][idx] == tag;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_way = WW'(w);
    end

    // Empty ways are filled lowest-first before the policy gets a say.
    always_comb begin
        victim = repl_victim;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[idx][w]) victim = WW'(w);
    end

    l1d_repl #(.WAYS(WAYS), .SETS(SETS)) u_repl (
        .CLK(CLK),
        .RST(RST),
        .set_idx(idx),
        .hit_en(state == LOOKUP && hit),
        .hit_way(hit_way),
        .fill_en(last_beat),
        .fill_way(vict_q),
        .victim(repl_victim)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            beat <= '0;
            for (int s = 0; s < SETS; s++)
                valid[s] <= '0;
            CPU_RESP_VALID <= 1'b0;
            CPU_RDATA <= '0;
            CPU_HIT <= 1'b0;
            MEM_REQ_VALID <= 1'b0;
            MEM_WE <= 1'b0;
            MEM_ADDR <= '0;
            MEM_WDATA <= '0;
        end else begin
            case (state)
                IDLE: if (CPU_REQ_VALID) state <= LOOKUP;
                LOOKUP: begin
                    MEM_WE <= we_q;
                    MEM_WDATA <= wdata_q;
                    MEM_ADDR <= we_q ? addr_q : {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
                    beat <= '0;
                    if (!we_q && hit) begin
                        state <= RESP;
                        CPU_RESP_VALID <= 1'b1;
                        CPU_HIT <= 1'b1;
                        CPU_RDATA <= data_mem[hit_way][idx][off];
                    end else begin
                        state <= we_q ? WR_REQ : MISS_REQ;
                        MEM_REQ_VALID <= 1'b1;
                    end
                end
                MISS_REQ, WR_REQ: if (MEM_REQ_READY) begin
                    MEM_REQ_VALID <= 1'b0;
                    state <= state == MISS_REQ ? REFILL : WR_WAIT;
                end
                REFILL: if (MEM_RDATA_VALID) begin
                    beat <= beat + 1'b1;
                    if (beat == off) CPU_RDATA <= MEM_RDATA;
                    if (last_beat) begin
                        valid[idx][vict_q] <= 1'b1;
                        state <= RESP;
                        CPU_RESP_VALID <= 1'b1;
                        CPU_HIT <= 1'b0;
                    end
                end
                WR_WAIT: if (MEM_RDATA_VALID) begin
                    state <= RESP;
                    CPU_RESP_VALID <= 1'b1;
                    CPU_HIT <= hit_q;
                end
                default: begin
                    state <= IDLE;
                    CPU_RESP_VALID <= 1'b0;
                    CPU_HIT <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data storage and request latches carry no reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (state == IDLE && CPU_REQ_VALID) begin
            addr_q <= CPU_ADDR;
            we_q <= CPU_WE;
            wdata_q <= CPU_WDATA;
        end
        if (state == LOOKUP) begin
            vict_q <= victim;
            hit_q <= hit;
            if (we_q && hit) data_mem[hit_way][idx][off] <= wdata_q;
        end
        if (state == REFILL && MEM_RDATA_VALID) line_buf[beat] <= MEM_RDATA;
        if (last_beat && !RST) begin
            tag_mem[vict_q][idx] <= tag;
            for (int j = 0; j < WORDS_PER_LINE; j++)
                data_mem[vict_q][idx][j] <= j == WORDS_PER_LINE - 1 ? MEM_RDATA : line_buf[j];
        end
    end

    always_ff @(posedge CLK)
        if (!RST && state == LOOKUP) assert ($onehot0(hit_vec));
endmodule

// File: tb/tb_l1d_setassoc_cache.sv
// tb_l1d_setassoc_cache: directed plus random checks of the L1 data cache against a line-list model.
module tb_l1d_setassoc_cache;
    localparam int WPL = 8;
    localparam int WAYS = 4;

    logic CLK = 1'b0, RST = 1'b1;
    logic CPU_REQ_VALID, CPU_REQ_READY, CPU_WE, CPU_RESP_VALID, CPU_HIT;
    logic [31:0] CPU_ADDR, CPU_WDATA, CPU_RDATA;
    logic MEM_REQ_VALID, MEM_REQ_READY, MEM_WE, MEM_RDATA_VALID;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

    always #5 CLK = ~CLK;

    l1d_setassoc_cache dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ_VALID(CPU_REQ_VALID), .CPU_REQ_READY(CPU_REQ_READY), .CPU_WE(CPU_WE),
        .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_RESP_VALID(CPU_RESP_VALID),
        .CPU_RDATA(CPU_RDATA), .CPU_HIT(CPU_HIT),
        .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_READY(MEM_REQ_READY), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA_VALID(MEM_RDATA_VALID), .MEM_RDATA(MEM_RDATA)
    );

    int n_cmp = 0, n_bad = 0;
    logic [31:0] wmem [logic [31:0]];
    logic [31:0] lines [$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : a + 32'hC0;
    endfunction

    function automatic int find_line(input logic [31:0] ln);
        foreach (lines[i]) if (lines[i] == ln) return i;
        return -1;
    endfunction

    function automatic void model_fill(input logic [31:0] ln);
        int cnt = 0, first = -1;
        foreach (lines[i])
            if (lines[i][3:0] == ln[3:0]) begin
                cnt++;
                if (first < 0) first = i;
            end
        if (cnt == WAYS) lines.delete(first);
        lines.push_back(ln);
    endfunction

    function automatic void model_touch(input int pos);
`ifdef L1D_LRU_EN
        logic [31:0] ln = lines[pos];
        lines.delete(pos);
        lines.push_back(ln);
`else
        if (pos < 0) $display("touch of an absent line");
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int rst_at, output logic got_hit);
        logic [31:0] ln, base, exp_data;
        int pos, n, beats, nreq;
        logic exp_hit, rd_pend, wr_pend, done, aborted;
        ln = addr >> 3;
        base = {addr[31:3], 3'b000};
        pos = find_line(ln);
        exp_hit = pos >= 0;
        exp_data = memval(addr);
        n = 0; beats = 0; nreq = 0;
        rd_pend = 0; wr_pend = 0; done = 0; aborted = 0;
        got_hit = 1'bx;
        @(negedge CLK);
        chk("ready_idle", CPU_REQ_READY, 1);
        CPU_REQ_VALID = 1; CPU_WE = we; CPU_ADDR = addr; CPU_WDATA = wd;
        while (!done && n < 300) begin
            @(negedge CLK);
            n++;
            CPU_REQ_VALID = 0;
            if (n == 1) chk("ready_busy", CPU_REQ_READY, 0);
            if (CPU_RESP_VALID) begin
                done = 1;
                got_hit = CPU_HIT;
                MEM_RDATA_VALID = 0;
                MEM_REQ_READY = 0;
                chk("hit", CPU_HIT, exp_hit);
                if (!we) chk("rdata", CPU_RDATA, exp_data);
                chk("mem_reqs", nreq, (we || !exp_hit) ? 1 : 0);
                if (!we && exp_hit) chk("hit_latency", n, 2);
                if (!we && !exp_hit) chk("beats", beats, WPL);
            end else if (rd_pend && beats < WPL && $urandom_range(3) != 0) begin
                MEM_RDATA_VALID = 1;
                MEM_RDATA = memval(base + beats);
                if (beats == rst_at) begin
                    RST = 1;
                    MEM_REQ_READY = 0;
                    @(negedge CLK);
                    MEM_RDATA_VALID = 0;
                    chk("rst_ready", CPU_REQ_READY, 0);
                    chk("rst_resp", CPU_RESP_VALID, 0);
                    chk("rst_memreq", MEM_REQ_VALID, 0);
                    RST = 0;
                    #1;
                    chk("post_rst_ready", CPU_REQ_READY, 1);
                    lines.delete();
                    done = 1;
                    aborted = 1;
                end
                beats++;
            end else begin
                MEM_RDATA_VALID = 0;
                if (wr_pend && $urandom_range(2) == 0) begin
                    MEM_RDATA_VALID = 1;
                    MEM_RDATA = $urandom;
                    wr_pend = 0;
                end else if (!rd_pend && !wr_pend && nreq == 0 && $urandom_range(3) == 0) begin
                    MEM_RDATA_VALID = 1;
                    MEM_RDATA = $urandom;
                end
                MEM_REQ_READY = 1'($urandom_range(1));
                if (MEM_REQ_VALID && MEM_REQ_READY) begin
                    nreq++;
                    chk("mem_we", MEM_WE, we);
                    chk("mem_addr", MEM_ADDR, we ? addr : base);
                    if (we) begin
                        chk("mem_wdata", MEM_WDATA, wd);
                        wr_pend = 1;
                    end else begin
                        rd_pend = 1;
                    end
                end
            end
        end
        chk("completed", done, 1);
        MEM_RDATA_VALID = 0;
        MEM_REQ_READY = 0;
        if (done && !aborted) begin
            if (we) wmem[addr] = wd;
            if (exp_hit) model_touch(pos);
            else if (!we) model_fill(ln);
            @(negedge CLK);
            chk("resp_pulse", CPU_RESP_VALID, 0);
        end
    endtask

    initial begin
        logic h, we;
        logic [31:0] a, ev;
        CPU_REQ_VALID = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_WDATA = 0;
        MEM_REQ_READY = 0; MEM_RDATA_VALID = 0; MEM_RDATA = 0;
        repeat (3) @(negedge CLK);
        chk("reset_ready", CPU_REQ_READY, 0);
        chk("reset_resp", CPU_RESP_VALID, 0);
        chk("reset_rdata", CPU_RDATA, 0);
        chk("reset_hit", CPU_HIT, 0);
        chk("reset_memreq", MEM_REQ_VALID, 0);
        chk("reset_memwe", MEM_WE, 0);
        chk("reset_memaddr", MEM_ADDR, 0);
        chk("reset_memwdata", MEM_WDATA, 0);
        RST = 0;
        #1;
        chk("ready_after_reset", CPU_REQ_READY, 1);

        do_req(0, 32'h40, 0, -1, h);
        chk("cold_miss", h, 0);
        do_req(0, 32'h43, 0, -1, h);
        chk("line_hit", h, 1);
        do_req(1, 32'h43, 32'hDEAD, -1, h);
        chk("store_hit", h, 1);
        do_req(0, 32'h43, 0, -1, h);
        chk("load_after_store", h, 1);

        for (int i = 0; i < 4; i++) do_req(0, 32'(i) << 7, 0, -1, h);
        do_req(0, 32'h0, 0, -1, h);
        chk("reread_line1", h, 1);
        do_req(0, 32'h200, 0, -1, h);
        chk("fifth_fill", h, 0);
`ifdef L1D_LRU_EN
        ev = 32'h80;
`else
        ev = 32'h0;
`endif
        do_req(0, ev, 0, -1, h);
        chk("evicted_line", h, 0);
        do_req(0, 32'h200, 0, -1, h);
        chk("survivor_line", h, 1);

        do_req(0, 32'h300, 0, 2, h);
        do_req(0, 32'h301, 0, -1, h);
        chk("reload_after_abort", h, 0);

        do_req(1, 32'h555, 32'h1234_5678, -1, h);
        chk("store_uncached", h, 0);
        do_req(0, 32'h555, 0, -1, h);
        chk("no_allocate", h, 0);

        repeat (200) begin
            we = $urandom_range(3) == 0;
            a = (32'($urandom_range(5)) << 7) | (32'($urandom_range(1)) << 3) | 32'($urandom_range(7));
            do_req(we, a, $urandom, -1, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
